// File: rtl/rv32_hazard_unit.sv
// Hazard, forwarding and flush controller for the pipelined rv32 core.
// Tracks the instructions in the post-decode stages (slot 0 = EX, slot DEPTH-1 = WB).
// From them it derives the EX forwarding selects, load-use stalls, taken-branch
// squashes and whole-pipeline freezes while dmem is busy.
module rv32_hazard_unit #(
    parameter  int DEPTH      = 3,
    parameter  int LOAD_READY = 2,
    parameter  int REG_AW     = 5,
    parameter  int CNT_W      = 32,
    localparam int FWD_W      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_we,
    input  logic              id_is_load,
    input  logic              ex_br_taken,
    input  logic              mem_stall,
    output logic              stall_pc,
    output logic              stall_ifid,
    output logic              flush_ifid,
    output logic              bubble_ex,
    output logic              hold_all,
    output logic [FWD_W-1:0]  fwd_a,
    output logic [FWD_W-1:0]  fwd_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    // Per-slot producer information, shifted down the pipe each active cycle.
    logic              slot_v  [DEPTH];
    logic              slot_we [DEPTH];
    logic              slot_ld [DEPTH];
    logic [REG_AW-1:0] slot_rd [DEPTH];

    // Source operands only matter for the consumer sitting in EX, so they are
    // kept for slot 0 alone; older slots never consume forwarded data.
    logic [REG_AW-1:0] ex_rs1;
    logic [REG_AW-1:0] ex_rs2;
    logic              ex_u1;
    logic              ex_u2;

    logic lu;
    logic br;

    // A slot supplies register r when it holds a live writer of r; x0 never matches.
    function automatic logic hit(input logic v, input logic we,
                                 input logic [REG_AW-1:0] rd,
                                 input logic [REG_AW-1:0] r);
        return v & we & (rd == r) & (r != '0);
    endfunction

    // Forwarding selects: scan oldest to youngest so the youngest producer wins.
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        for (int s = DEPTH - 1; s >= 1; s--) begin
            if (slot_v[0] && ex_u1 && hit(slot_v[s], slot_we[s], slot_rd[s], ex_rs1))
                fwd_a = FWD_W'(s);
            if (slot_v[0] && ex_u2 && hit(slot_v[s], slot_we[s], slot_rd[s], ex_rs2))
                fwd_b = FWD_W'(s);
        end
    end

    // Load-use detection: a load whose data is not yet forwardable feeds the ID instruction.
    always_comb begin
        lu = 1'b0;
        for (int s = 0; s < LOAD_READY - 1; s++) begin
            if (id_valid && slot_ld[s] &&
                ((id_rs1_used && hit(slot_v[s], slot_we[s], slot_rd[s], id_rs1)) ||
                 (id_rs2_used && hit(slot_v[s], slot_we[s], slot_rd[s], id_rs2))))
                lu = 1'b1;
        end
    end

    assign br = ex_br_taken & slot_v[0] & ~mem_stall;

    // Pipeline control priority: freeze, then branch squash, then load-use stall.
    // The freeze is qualified with reset so nothing is asserted while rst is low.
    always_comb begin
        hold_all   = 1'b0;
        stall_pc   = 1'b0;
        stall_ifid = 1'b0;
        flush_ifid = 1'b0;
        bubble_ex  = 1'b0;
        if (rst && mem_stall) begin
            hold_all   = 1'b1;
            stall_pc   = 1'b1;
            stall_ifid = 1'b1;
        end else if (br) begin
            flush_ifid = 1'b1;
            bubble_ex  = 1'b1;
        end else if (lu) begin
            stall_pc   = 1'b1;
            stall_ifid = 1'b1;
            bubble_ex  = 1'b1;
        end
    end

    // Tracker shift and performance counters; everything holds while dmem stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < DEPTH; s++) begin
                slot_v[s]  <= 1'b0;
                slot_we[s] <= 1'b0;
                slot_ld[s] <= 1'b0;
                slot_rd[s] <= '0;
            end
            ex_rs1    <= '0;
            ex_rs2    <= '0;
            ex_u1     <= 1'b0;
            ex_u2     <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (!mem_stall) begin
            for (int s = DEPTH - 1; s >= 1; s--) begin
                slot_v[s]  <= slot_v[s-1];
                slot_we[s] <= slot_we[s-1];
                slot_ld[s] <= slot_ld[s-1];
                slot_rd[s] <= slot_rd[s-1];
            end
            slot_v[0]  <= id_valid & ~bubble_ex;
            slot_we[0] <= id_we;
            slot_ld[0] <= id_is_load;
            slot_rd[0] <= id_rd;
            ex_rs1     <= id_rs1;
            ex_rs2     <= id_rs2;
            ex_u1      <= id_rs1_used;
            ex_u2      <= id_rs2_used;
            if (br)
                flush_cnt <= flush_cnt + CNT_W'(1);
            if (lu && !br)
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
